// File: rtl/core_pkg.sv
// core_pkg: shared memory-stage types, pipeline register layouts and load/store constants.
package core_pkg;

    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              byte_addr;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rd;
    } memwb_t;

endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane strobes and store replication, plus zero-extended byte extraction for loads.
module mem_align
    import core_pkg::*;
(
    input  logic            byte_addr,
    input  logic            is_store,
    input  logic            is_load,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);

    always_comb begin
        wstrb      = is_store ? (byte_addr ? 4'b0001 << addr_lo : 4'hF) : 4'h0;
        wdata_lane = is_store ? (byte_addr ? {4{wdata[7:0]}} : wdata) : '0;
        rdata_ext  = is_load ? (byte_addr ? {24'b0, rdata[8*addr_lo +: 8]} : rdata) : '0;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage - EX/MEM and MEM/WB registers, data-cache handshake, byte alignment.
// Optional MEM_STAGE_PERF_EN adds miss and stall performance counters.
module mem_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              CLR,
    input  logic                              RegWriteE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              MemWriteE,
    input  logic                              ByteAddrE,
    input  logic [DATA_WIDTH-1:0]             ALUResultE,
    input  logic [DATA_WIDTH-1:0]             WriteDataE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
    output logic                              MemReqM,
    output logic                              MemWeM,
    output logic [DATA_WIDTH-1:0]             MemAddrM,
    output logic [3:0]                        MemWStrbM,
    output logic [DATA_WIDTH-1:0]             MemWDataM,
    input  logic                              MemAckM,
    input  logic [DATA_WIDTH-1:0]             MemRDataM,
    output logic                              StallM,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
    output logic                              RegWriteM,
    output logic                              RegWriteW,
    output logic [1:0]                        ResultSrcW,
    output logic [DATA_WIDTH-1:0]             ReadDataW,
    output logic [DATA_WIDTH-1:0]             ALUResultW,
    output logic [DATA_WIDTH-1:0]             PCPlus4W,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] RdW
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]                       PerfMissCntM,
    output logic [31:0]                       PerfStallCntM
`endif
);

    exmem_t          ex_q;
    memwb_t          wb_q;
    mem_state_t      state_q, state_d;
    logic            is_load, is_store, memop;
    logic [XLEN-1:0] read_data;

    assign is_load  = ex_q.result_src == RESULT_SRC_LOAD;
    assign is_store = ex_q.mem_write;
    assign memop    = is_load | is_store;

    // The held EX/MEM op keeps the request stable for the whole miss.
    assign MemReqM    = memop;
    assign MemWeM     = is_store;
    assign MemAddrM   = {ex_q.alu_result[XLEN-1:2], 2'b00};
    assign StallM     = MemReqM & ~MemAckM;
    assign ALUResultM = ex_q.alu_result;
    assign RdM        = ex_q.rd;
    assign RegWriteM  = ex_q.reg_write;

    mem_align u_align (
        .byte_addr  (ex_q.byte_addr),
        .is_store   (is_store),
        .is_load    (is_load),
        .addr_lo    (ex_q.alu_result[1:0]),
        .wdata      (ex_q.write_data),
        .rdata      (MemRDataM),
        .wstrb      (MemWStrbM),
        .wdata_lane (MemWDataM),
        .rdata_ext  (read_data)
    );

    always_ff @(posedge clk) begin
        if (CLR) begin
            ex_q <= '0;
        end else if (!StallM) begin
            ex_q <= '{
                reg_write:  RegWriteE,
                result_src: ResultSrcE,
                mem_write:  MemWriteE,
                byte_addr:  ByteAddrE,
                alu_result: ALUResultE,
                write_data: WriteDataE,
                pc_plus4:   PCPlus4E,
                rd:         RdE
            };
        end
    end

    // A stalled cycle sends a bubble into writeback; the ack edge retires the op.
    always_ff @(posedge clk) begin
        if (CLR || StallM) begin
            wb_q <= '0;
        end else begin
            wb_q <= '{
                reg_write:  ex_q.reg_write,
                result_src: ex_q.result_src,
                read_data:  read_data,
                alu_result: ex_q.alu_result,
                pc_plus4:   ex_q.pc_plus4,
                rd:         ex_q.rd
            };
        end
    end

    assign RegWriteW  = wb_q.reg_write;
    assign ResultSrcW = wb_q.result_src;
    assign ReadDataW  = wb_q.read_data;
    assign ALUResultW = wb_q.alu_result;
    assign PCPlus4W   = wb_q.pc_plus4;
    assign RdW        = wb_q.rd;

    always_ff @(posedge clk) begin
        state_q <= CLR ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = (memop && !MemAckM) ? WAIT : IDLE;
        else state_d = MemAckM ? IDLE : WAIT;
    end

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (CLR) begin
            PerfMissCntM  <= '0;
            PerfStallCntM <= '0;
        end else begin
            if (state_q == IDLE && state_d == WAIT) PerfMissCntM <= PerfMissCntM + 32'd1;
            if (StallM) PerfStallCntM <= PerfStallCntM + 32'd1;
        end
    end
`endif

endmodule
